// File: rtl/hls_deadlock_report_arbiter_pkg.sv
// Shared types and widths for the deadlock report arbiter and its helpers.
package hls_deadlock_report_arbiter_pkg;

  localparam int unsigned SRC_ID_W = 4;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic [0:0] {
    StIdle,
    StOffer
  } state_e;

endpackage

// File: rtl/hls_deadlock_rr_pick.sv
// Combinational round-robin search: first set pending bit at or after ptr_i, wrapping.
module hls_deadlock_rr_pick
  import hls_deadlock_report_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC = 7
) (
  input  logic [N_SRC-1:0]    pending_i,
  input  logic [SRC_ID_W-1:0] ptr_i,
  output logic                found_o,
  output logic [SRC_ID_W-1:0] idx_o
);

  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;

  // Rotating a doubled copy puts the pointer position at bit 0.
  assign dbl = {pending_i, pending_i};
  assign rot = dbl[ptr_i +: N_SRC];

  always_comb begin
    int s;
    s       = 0;
    found_o = |rot;
    idx_o   = '0;
    // Walk downwards so the lowest rotated offset wins.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        s = int'(ptr_i) + k;
        if (s >= int'(N_SRC)) begin
          s = s - int'(N_SRC);
        end
        idx_o = SRC_ID_W'(s);
      end
    end
  end

endmodule

// File: rtl/hls_deadlock_report_arbiter.sv
// Debounces per-source deadlock flags and reports each confirmed episode once, round-robin.
module hls_deadlock_report_arbiter
  import hls_deadlock_report_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC  = 7,
  parameter int unsigned THRESH = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_SRC-1:0]    block_in,
  input  logic                clear,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [SRC_ID_W-1:0] rpt_src_id,
  output logic                any_block
);

  localparam logic [CNT_W-1:0] ThreshCnt   = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] ThreshCntM1 = CNT_W'(THRESH - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q [N_SRC];
  logic [CNT_W-1:0]     cnt_d [N_SRC];
  logic [N_SRC-1:0]     pending_q, pending_d;
  logic [N_SRC-1:0]     reported_q, reported_d;
  logic [N_SRC-1:0]     pend_set, ack_mask;
  logic [SRC_ID_W-1:0]  rr_ptr_q, rr_ptr_next;
  logic [SRC_ID_W-1:0]  rpt_src_id_q;
  logic                 rpt_valid_q;
  logic                 any_block_q;
  logic                 ack;
  logic                 pick_found;
  logic [SRC_ID_W-1:0]  pick_idx;

  hls_deadlock_rr_pick #(
    .N_SRC(N_SRC)
  ) u_pick (
    .pending_i(pending_q),
    .ptr_i    (rr_ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  assign ack         = (state_q == StOffer) && rpt_ready;
  assign rr_ptr_next = (rpt_src_id_q == SRC_ID_W'(N_SRC - 1)) ? '0
                                                               : rpt_src_id_q + SRC_ID_W'(1);

  always_comb begin
    cnt_d    = cnt_q;
    pend_set = '0;
    ack_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!block_in[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != ThreshCnt) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      pend_set[i] = block_in[i] && (cnt_q[i] == ThreshCntM1) && !reported_q[i];
      ack_mask[i] = ack && (rpt_src_id_q == SRC_ID_W'(i));
    end
    pending_d  = (pending_q | pend_set) & ~ack_mask;
    // An ack that lands after the flag already dropped must not block the next episode.
    reported_d = (reported_q | ack_mask) & block_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '{default: '0};
      pending_q    <= '0;
      reported_q   <= '0;
      rr_ptr_q     <= '0;
      rpt_src_id_q <= '0;
      rpt_valid_q  <= 1'b0;
      any_block_q  <= 1'b0;
    end else if (clear) begin
      state_q     <= StIdle;
      cnt_q       <= '{default: '0};
      pending_q   <= '0;
      reported_q  <= '0;
      rpt_valid_q <= 1'b0;
      any_block_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      reported_q  <= reported_d;
      any_block_q <= |pending_q;
      case (state_q)
        StIdle: begin
          if (pick_found) begin
            rpt_src_id_q <= pick_idx;
            rpt_valid_q  <= 1'b1;
            state_q      <= StOffer;
          end
        end
        StOffer: begin
          if (rpt_ready) begin
            rpt_valid_q <= 1'b0;
            rr_ptr_q    <= rr_ptr_next;
            state_q     <= StIdle;
          end
        end
        default: begin
          rpt_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign rpt_valid  = rpt_valid_q;
  assign rpt_src_id = rpt_src_id_q;
  assign any_block  = any_block_q;

endmodule

// File: tb/tb_hls_deadlock_report_arbiter.sv
// Scoreboard bench: a run-length reference model predicts reports; a monitor checks the DUT.
module tb_hls_deadlock_report_arbiter;

  localparam int N  = 7;
  localparam int TH = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         clear;
  logic [N-1:0] block_in;
  logic         rpt_valid;
  logic         rpt_ready;
  logic [3:0]   rpt_src_id;
  logic         any_block;

  always #5 clock = ~clock;

  hls_deadlock_report_arbiter #(
    .N_SRC (N),
    .THRESH(TH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .block_in  (block_in),
    .clear     (clear),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_src_id(rpt_src_id),
    .any_block (any_block)
  );

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;
  int exp_q[$];
  int seen_q[$];

  // Reference model state: run lengths rather than saturating counters.
  int run [N];
  bit pend[N];
  bit rep [N];
  bit m_off, m_any;
  int m_id, m_ptr;

  bit cmp_valid, cmp_any;
  int cmp_id;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input logic [N-1:0] b, input bit clr, input bit rdy,
                                     input bit rst);
    bit np[N];
    bit ack, fresh, hit, any_now, found;
    int j;
    if (rst || clr) begin
      for (int i = 0; i < N; i++) begin
        run[i] = 0; pend[i] = 0; rep[i] = 0;
      end
      m_off = 0;
      m_any = 0;
      if (rst) begin
        m_id  = 0;
        m_ptr = 0;
      end
      return;
    end
    ack     = m_off && rdy;
    any_now = 0;
    for (int i = 0; i < N; i++) begin
      any_now |= pend[i];
      fresh   = b[i] && (run[i] + 1 == TH) && !rep[i];
      hit     = ack && (i == m_id);
      np[i]   = (pend[i] || fresh) && !hit;
      rep[i]  = b[i] && (rep[i] || hit);
      run[i]  = b[i] ? run[i] + 1 : 0;
    end
    if (m_off) begin
      if (ack) begin
        exp_q.push_back(m_id);
        m_off = 0;
        m_ptr = (m_id + 1) % N;
      end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!found && pend[j]) begin
          found = 1;
          m_off = 1;
          m_id  = j;
        end
      end
    end
    for (int i = 0; i < N; i++) pend[i] = np[i];
    m_any = any_now;
  endfunction

  task automatic cyc(input logic [N-1:0] b, input bit clr, input bit rdy, input bit rst);
    block_in  = b;
    clear     = clr;
    rpt_ready = rdy;
    reset     = rst;
    cmp_valid = m_off;
    cmp_any   = m_any;
    cmp_id    = m_id;
    model_step(b, clr, rdy, rst);
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input logic [N-1:0] b, input bit rdy, input int n);
    for (int c = 0; c < n; c++) cyc(b, 1'b0, rdy, 1'b0);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      check("rpt_valid", {31'd0, rpt_valid}, {31'd0, cmp_valid});
      check("any_block", {31'd0, any_block}, {31'd0, cmp_any});
      if (cmp_valid) check("rpt_src_id", {28'd0, rpt_src_id}, cmp_id);
      if (rpt_valid === 1'b1 && rpt_ready && !clear && !reset) begin
        hs_count++;
        seen_q.push_back(int'(rpt_src_id));
        if (exp_q.size() == 0) begin
          check("unexpected_report", {28'd0, rpt_src_id}, 32'hFFFF_FFFF);
        end else begin
          check("report_id", {28'd0, rpt_src_id}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int hs0;
    logic [N-1:0] blk;
    m_off = 0; m_any = 0; m_id = 0; m_ptr = 0;
    cyc('0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    cyc('0, 1'b0, 1'b0, 1'b1);
    hold('0, 1'b0, 2);

    // Single long block on source 2: exactly one report.
    hs0 = hs_count;
    hold(7'b0000100, 1'b1, 10);
    hold('0, 1'b1, 3);
    check("single_episode_reports", hs_count - hs0, 1);

    // Short pulse never confirms.
    hs0 = hs_count;
    hold(7'b0001000, 1'b1, 3);
    hold('0, 1'b1, 6);
    check("short_pulse_reports", hs_count - hs0, 0);

    // Report source 3 to leave the pointer at 4, then confirm 0, 3, 6 together.
    hold(7'b0001000, 1'b1, 6);
    hold('0, 1'b1, 2);
    seen_q.delete();
    hold(7'b1001001, 1'b1, 12);
    hold('0, 1'b1, 4);
    check("rr_count", seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      check("rr_first", seen_q[0], 6);
      check("rr_second", seen_q[1], 0);
      check("rr_third", seen_q[2], 3);
    end

    // Held offer survives the flag dropping.
    hold(7'b0100000, 1'b0, 5);
    hold('0, 1'b0, 15);
    hold('0, 1'b1, 3);

    // Clear collides with a handshake; source 1 must be reportable again afterwards.
    hold(7'b0000010, 1'b0, 6);
    cyc(7'b0000010, 1'b1, 1'b1, 1'b0);
    hs0 = hs_count;
    hold(7'b0000010, 1'b1, 8);
    hold('0, 1'b1, 2);
    check("report_after_clear", hs_count - hs0, 1);

    // Reset during an offer.
    hold(7'b0010000, 1'b0, 6);
    hs0 = hs_count;
    cyc(7'b0010000, 1'b0, 1'b1, 1'b1);
    hold('0, 1'b1, 3);
    check("reset_mid_offer_reports", hs_count - hs0, 0);

    // Randomized traffic with occasional clear and reset.
    blk = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) blk[i] = ~blk[i];
      end
      cyc(blk, ($urandom_range(63) == 0), ($urandom_range(1) == 1), ($urandom_range(255) == 0));
    end
    hold('0, 1'b1, 8);

    check("leftover_expected", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
